// File: rtl/pool_window_unit.sv
// pool_window_unit
//   Multi-lane pooling engine. Every WIN accepted beats are reduced per lane
//   into one pooled sample, either the maximum or the floor average. The
//   window mode is latched on the first beat of the window.
//
// Handshake rules (both ports):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   The source keeps valid and data stable until that transfer. in_ready is
//   low only while a result is held and not taken. in_ready does not depend
//   on in_valid.
//
// Ports:
//   clk, n_reset   clock, synchronous active-low reset
//   mode           0 = max, 1 = average (sampled on the first beat of a window)
//   flush          drop the partial window and any beat accepted this cycle
//   in_valid/in_ready/in_data     input beats, lane i = [i*DATA_W +: DATA_W]
//   out_valid/out_ready/out_data  pooled results, same lane packing
//   busy           partial window in progress (beat counter non-zero)
module pool_window_unit #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int WIN    = 4
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     mode,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATA_W-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*DATA_W-1:0]  out_data,
    output logic                     busy
);

    localparam int CNT_W = $clog2(WIN);
    localparam int ACC_W = DATA_W + CNT_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN - 1);

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      mode_q, mode_d;
    logic signed [ACC_W-1:0]   acc_q [LANES];
    logic signed [ACC_W-1:0]   acc_d [LANES];
    logic                      out_valid_q, out_valid_d;
    logic [LANES*DATA_W-1:0]   out_data_q, out_data_d;

    logic                      accept;
    logic                      first_beat;
    logic                      last_beat;
    logic                      win_mode;
    logic signed [ACC_W-1:0]   sample_ext [LANES];
    logic signed [ACC_W-1:0]   merged     [LANES];
    logic signed [ACC_W-1:0]   avg_shift  [LANES];
    logic [LANES*DATA_W-1:0]   result;

    assign in_ready   = !(out_valid_q && !out_ready);
    assign accept     = in_valid && in_ready;
    assign first_beat = (cnt_q == '0);
    assign last_beat  = (cnt_q == LAST_CNT);
    // The first beat of a window uses the live mode input; later beats use
    // the value latched with that first beat.
    assign win_mode   = first_beat ? mode : mode_q;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (cnt_q != '0);

    // Per-lane merge of the accumulator with the incoming beat. Max values
    // are kept sign-extended to ACC_W so one signed compare covers both modes.
    always_comb begin
        result = '0;
        for (int i = 0; i < LANES; i++) begin
            sample_ext[i] = ACC_W'($signed(in_data[i*DATA_W +: DATA_W]));
            if (first_beat) begin
                merged[i] = sample_ext[i];
            end else if (win_mode) begin
                merged[i] = acc_q[i] + sample_ext[i];
            end else begin
                // Tie goes to the new sample.
                merged[i] = (acc_q[i] <= sample_ext[i]) ? sample_ext[i] : acc_q[i];
            end
            // Arithmetic shift floors toward -inf; the quotient of a sum of
            // WIN samples always fits back into DATA_W.
            avg_shift[i] = merged[i] >>> CNT_W;
            result[i*DATA_W +: DATA_W] = win_mode ? avg_shift[i][DATA_W-1:0]
                                                  : merged[i][DATA_W-1:0];
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        for (int i = 0; i < LANES; i++) begin
            acc_d[i] = acc_q[i];
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            // Flush drops the window and any beat taken this cycle, but a
            // pending result is still delivered.
            cnt_d  = '0;
            mode_d = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                acc_d[i] = '0;
            end
        end else if (accept) begin
            if (last_beat) begin
                // A new result overrides the handshake clear above, so a
                // result taken this cycle is replaced without a bubble.
                cnt_d       = '0;
                out_valid_d = 1'b1;
                out_data_d  = result;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                for (int i = 0; i < LANES; i++) begin
                    acc_d[i] = merged[i];
                end
                if (first_beat) begin
                    mode_d = mode;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pool_window_unit.sv
// tb_pool_window_unit
//   Directed scenarios plus a randomized stream for pool_window_unit. The
//   reference model pools whole windows with integer arithmetic: maximum of
//   the signed samples, or the floor of the mean.
module tb_pool_window_unit;

    localparam int W   = 16;
    localparam int L   = 4;
    localparam int WIN = 4;
    localparam int LW  = W * L;

    logic          clk;
    logic          n_reset;
    logic          mode;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_data;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;
    logic [LW-1:0] exp_q[$];

    pool_window_unit #(.DATA_W(W), .LANES(L), .WIN(WIN)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .mode      (mode),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [LW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    function automatic logic [LW-1:0] ref_pool(input logic [LW-1:0] b [WIN], input logic m);
        logic [LW-1:0]       r;
        logic signed [W-1:0] s;
        int v, best, sum, q;
        r = '0;
        for (int l = 0; l < L; l++) begin
            best = 0;
            sum  = 0;
            for (int k = 0; k < WIN; k++) begin
                s = b[k][l*W +: W];
                v = s;
                if (k == 0 || v > best) best = v;
                sum += v;
            end
            if (m) begin
                q = sum / WIN;
                if ((sum % WIN) != 0 && sum < 0) q = q - 1;
            end else begin
                q = best;
            end
            r[l*W +: W] = q[W-1:0];
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic [LW-1:0] d, input logic m,
                        input logic f, input logic r);
        in_valid  = v;
        in_data   = d;
        mode      = m;
        flush     = f;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r);
        step(1'b0, '0, 1'b0, 1'b0, r);
    endtask

    function automatic logic [LW-1:0] rnd_beat();
        return {$urandom, $urandom};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        n_reset = 1'b0;
        idle(1'b1);
        idle(1'b1);
        n_reset = 1'b1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_max();
        logic [LW-1:0] bt [WIN];
        logic [LW-1:0] e;
        bt = '{pack4(3, -1, 100, -200), pack4(-7, -9, 50, -100),
               pack4(12, -2, -5, -300), pack4(5, -5, 0, -150)};
        e = ref_pool(bt, 1'b0);
        for (int k = 0; k < WIN - 1; k++) step(1'b1, bt[k], 1'b0, 1'b0, 1'b1);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL max_busy_mid: got %b want 1", busy); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL max_early_valid: got %b want 0", out_valid); end
        step(1'b1, bt[WIN-1], 1'b0, 1'b0, 1'b1);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL max_latency: got %b want 1", out_valid); end
        n_vec++; if (out_data !== e) begin n_err++; $display("FAIL max_data: got %h want %h", out_data, e); end
        n_vec++; if (out_data[W-1:0] !== W'(12)) begin n_err++; $display("FAIL max_lane0: got %h want 000c", out_data[W-1:0]); end
        n_vec++; if (out_data[2*W-1:W] !== W'(-1)) begin n_err++; $display("FAIL max_lane1: got %h want ffff", out_data[2*W-1:W]); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL max_busy_end: got %b want 0", busy); end
        idle(1'b1);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL max_valid_clear: got %b want 0", out_valid); end
    endtask

    task automatic test_avg();
        logic [LW-1:0] bt [WIN];
        logic [LW-1:0] e;
        bt = '{pack4(10, -1, 32767, -32768), pack4(11, -1, 32767, -32768),
               pack4(-4, -1, 32767, -32768), pack4(0, -2, 32767, -32768)};
        e = ref_pool(bt, 1'b1);
        for (int k = 0; k < WIN; k++) step(1'b1, bt[k], 1'b1, 1'b0, 1'b1);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL avg_valid: got %b want 1", out_valid); end
        n_vec++; if (out_data !== e) begin n_err++; $display("FAIL avg_data_model: got %h want %h", out_data, e); end
        n_vec++; if (out_data !== pack4(4, -2, 32767, -32768)) begin n_err++; $display("FAIL avg_data_const: got %h want %h", out_data, pack4(4, -2, 32767, -32768)); end
        idle(1'b1);
    endtask

    task automatic test_backpressure();
        logic [LW-1:0] a [WIN];
        logic [LW-1:0] b [WIN];
        logic [LW-1:0] c [WIN];
        logic [LW-1:0] ea, eb, ec;
        for (int k = 0; k < WIN; k++) begin
            a[k] = rnd_beat(); b[k] = rnd_beat(); c[k] = rnd_beat();
        end
        ea = ref_pool(a, 1'b0);
        eb = ref_pool(b, 1'b1);
        ec = ref_pool(c, 1'b0);
        for (int k = 0; k < WIN; k++) step(1'b1, a[k], 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 5; t++) begin
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", t, in_ready); end
            n_vec++; if (out_valid !== 1'b1 || out_data !== ea) begin n_err++; $display("FAIL bp_hold[%0d]: valid=%b data=%h want 1 %h", t, out_valid, out_data, ea); end
            // Beats offered while stalled must not be taken.
            step(1'b1, rnd_beat(), 1'b1, 1'b0, 1'b0);
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_no_accept[%0d]: busy=%b want 0", t, busy); end
        end
        // Result A is taken on the same edge as the first beat of B.
        step(1'b1, b[0], 1'b1, 1'b0, 1'b1);
        n_vec++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL bp_release: valid=%b busy=%b want 0 1", out_valid, busy); end
        for (int k = 1; k < WIN; k++) step(1'b1, b[k], 1'b0, 1'b0, 1'b1);
        n_vec++; if (out_valid !== 1'b1 || out_data !== eb) begin n_err++; $display("FAIL stream_b: valid=%b data=%h want 1 %h", out_valid, out_data, eb); end
        for (int k = 0; k < WIN; k++) begin
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %b want 1", k, in_ready); end
            step(1'b1, c[k], 1'b0, 1'b0, 1'b1);
        end
        n_vec++; if (out_valid !== 1'b1 || out_data !== ec) begin n_err++; $display("FAIL stream_c: valid=%b data=%h want 1 %h", out_valid, out_data, ec); end
        idle(1'b1);
    endtask

    task automatic test_flush();
        logic [LW-1:0] bt [WIN];
        logic [LW-1:0] e;
        step(1'b1, pack4(1000, 1000, 1000, 1000), 1'b0, 1'b0, 1'b1);
        step(1'b1, pack4(900, 900, 900, 900), 1'b0, 1'b0, 1'b1);
        step(1'b1, pack4(800, 800, 800, 800), 1'b0, 1'b1, 1'b1);
        n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_mid: busy=%b valid=%b want 0 0", busy, out_valid); end
        bt = '{pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), pack4(3, 3, 3, 3), pack4(4, 4, 4, 4)};
        for (int k = 0; k < WIN; k++) step(1'b1, bt[k], 1'b0, 1'b0, 1'b1);
        n_vec++; if (out_valid !== 1'b1 || out_data !== pack4(4, 4, 4, 4)) begin n_err++; $display("FAIL flush_next_window: valid=%b data=%h want 1 %h", out_valid, out_data, pack4(4, 4, 4, 4)); end
        idle(1'b1);
        // Flush together with a final beat: no result.
        for (int k = 0; k < WIN - 1; k++) step(1'b1, rnd_beat(), 1'b0, 1'b0, 1'b1);
        step(1'b1, rnd_beat(), 1'b0, 1'b1, 1'b1);
        n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL flush_final: valid=%b busy=%b want 0 0", out_valid, busy); end
        // Flush with a pending result: result survives.
        for (int k = 0; k < WIN; k++) bt[k] = rnd_beat();
        e = ref_pool(bt, 1'b1);
        for (int k = 0; k < WIN; k++) step(1'b1, bt[k], 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_vec++; if (out_valid !== 1'b1 || out_data !== e) begin n_err++; $display("FAIL flush_pending: valid=%b data=%h want 1 %h", out_valid, out_data, e); end
        idle(1'b1);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_pending_taken: got %b want 0", out_valid); end
    endtask

    task automatic test_mode_latch();
        logic [LW-1:0] bt [WIN];
        logic [LW-1:0] e;
        logic [2:0] ms [2];
        ms = '{3'b111, 3'b000};
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < WIN; k++) bt[k] = rnd_beat();
            e = ref_pool(bt, p[0]);
            step(1'b1, bt[0], p[0], 1'b0, 1'b1);
            for (int k = 1; k < WIN; k++) step(1'b1, bt[k], ms[p][k-1], 1'b0, 1'b1);
            n_vec++; if (out_valid !== 1'b1 || out_data !== e) begin n_err++; $display("FAIL mode_latch[%0d]: valid=%b data=%h want 1 %h", p, out_valid, out_data, e); end
        end
        for (int k = 0; k < WIN; k++) step(1'b1, pack4(-3, -3, 7, -32768), 1'b0, 1'b0, 1'b1);
        n_vec++; if (out_data !== pack4(-3, -3, 7, -32768)) begin n_err++; $display("FAIL max_tie: got %h want %h", out_data, pack4(-3, -3, 7, -32768)); end
        idle(1'b1);
    endtask

    task automatic test_reset_mid();
        logic [LW-1:0] bt [WIN];
        logic [LW-1:0] e;
        step(1'b1, pack4(30000, 30000, 30000, 30000), 1'b1, 1'b0, 1'b1);
        step(1'b1, pack4(30000, 30000, 30000, 30000), 1'b1, 1'b0, 1'b1);
        n_reset = 1'b0;
        step(1'b1, pack4(30000, 30000, 30000, 30000), 1'b1, 1'b0, 1'b1);
        n_reset = 1'b1;
        n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin n_err++; $display("FAIL reset_mid_window: busy=%b valid=%b data=%h want 0 0 0", busy, out_valid, out_data); end
        for (int k = 0; k < WIN; k++) step(1'b1, rnd_beat(), 1'b0, 1'b0, 1'b0);
        n_reset = 1'b0;
        idle(1'b0);
        n_reset = 1'b1;
        n_vec++; if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_pending: valid=%b data=%h busy=%b want 0 0 0", out_valid, out_data, busy); end
        for (int k = 0; k < WIN; k++) bt[k] = pack4(-k - 1, k * 3, 5 - k, -100 + k);
        e = ref_pool(bt, 1'b0);
        for (int k = 0; k < WIN; k++) step(1'b1, bt[k], 1'b0, 1'b0, 1'b1);
        n_vec++; if (out_valid !== 1'b1 || out_data !== e) begin n_err++; $display("FAIL reset_after_window: valid=%b data=%h want 1 %h", out_valid, out_data, e); end
        idle(1'b1);
    endtask

    task automatic test_random();
        logic [LW-1:0] wb [WIN];
        logic [LW-1:0] e;
        int  wcnt = 0;
        logic wmode = 1'b0;
        logic acc, dlv;
        int  guard;
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = rnd_beat();
            mode      = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            n_vec++; if (in_ready !== !(out_valid && !out_ready)) begin n_err++; $display("FAIL rnd_in_ready@%0d: got %b (out_valid=%b out_ready=%b)", cyc, in_ready, out_valid, out_ready); end
            n_vec++; if (busy !== (wcnt != 0)) begin n_err++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, busy, wcnt != 0); end
            acc = in_valid && in_ready;
            dlv = out_valid && out_ready;
            if (dlv) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL rnd_spurious@%0d: got %h with no result expected", cyc, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin n_err++; $display("FAIL rnd_data@%0d: got %h want %h", cyc, out_data, e); end
                end
            end
            if (flush) begin
                wcnt = 0;
            end else if (acc) begin
                if (wcnt == 0) wmode = mode;
                wb[wcnt] = in_data;
                wcnt++;
                if (wcnt == WIN) begin
                    exp_q.push_back(ref_pool(wb, wmode));
                    wcnt = 0;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            #1;
            if (out_valid) begin
                e = exp_q.pop_front();
                n_vec++; if (out_data !== e) begin n_err++; $display("FAIL rnd_drain: got %h want %h", out_data, e); end
            end
            @(posedge clk);
            #1;
            guard++;
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd_missing: %0d results never delivered, want 0", exp_q.size()); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rnd_extra: out_valid=%b after drain, want 0", out_valid); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_reset   = 1'b0;
        mode      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        test_reset();
        test_max();
        test_avg();
        test_backpressure();
        test_flush();
        test_mode_latch();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
